// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CPU control sequencer.
// State encoding, counter opcodes and status bit positions.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_WB      = 3'd4,
    S_SLEEP   = 3'd5,
    S_IRQ     = 3'd6,
    S_FAULT   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CNT_HOLD,
    CNT_CLR,
    CNT_LOAD,
    CNT_INC,
    CNT_DEC
  } cnt_op_e;

  localparam int IRQ_BIT   = 7;
  localparam int BUSY_BIT  = 5;
  localparam int OVF_BIT   = 3;
  localparam int FAULT_BIT = 0;
  localparam int CTR_W     = 8;

  function automatic logic is_busy(state_e s);
    return s inside {S_FETCH, S_DECODE, S_EXECUTE,
                     S_WB, S_IRQ};
  endfunction

endpackage

// File: rtl/cpu_ctrl_cnt.sv
// Shared 8-bit counter: fetch wait timer and execute countdown.
// Ports: clk, reset (async low), op, load_val -> count.
module cpu_ctrl_cnt
  import cpu_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  cnt_op_e          op,
  input  logic [CTR_W-1:0] load_val,
  output logic [CTR_W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      case (op)
        CNT_CLR:  count <= '0;
        CNT_LOAD: count <= load_val;
        CNT_INC:  count <= count + 8'd1;
        CNT_DEC:  count <= count - 8'd1;
        default:  count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// CPU control sequencer: fetch/decode/execute/writeback, irq, sleep.
// Ports: clk, reset, start, sleep/wakeup/irq requests, mem_ready,
// exec_stall -> mem_req, irq_ack, state, status, retired_count, fault.
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int EXEC_CYCLES   = 1,
  parameter int FETCH_TIMEOUT = 8,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sleep_request,
  input  logic             wakeup_request,
  input  logic             irq_req,
  input  logic             irq_en,
  input  logic             mem_ready,
  input  logic             exec_stall,
  output logic             mem_req,
  output logic             irq_ack,
  output logic [2:0]       state,
  output logic [7:0]       status,
  output logic [CNT_W-1:0] retired_count,
  output logic             fault
);

  localparam logic [CTR_W-1:0] TO_LAST =
    CTR_W'(FETCH_TIMEOUT - 1);
  localparam logic [CTR_W-1:0] EX_LOAD =
    CTR_W'(EXEC_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE = 1;

  state_e           state_q;
  state_e           state_d;
  cnt_op_e          op;
  logic [CTR_W-1:0] cnt;
  logic             irq_take;
  logic             irq_q;
  logic             busy_q;
  logic             ovf_q;

  assign irq_take = irq_req & irq_en;

  cpu_ctrl_cnt u_cnt (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .load_val (EX_LOAD),
    .count    (cnt)
  );

  always_comb begin
    state_d = state_q;
    op      = CNT_CLR;
    unique case (state_q)
      S_IDLE: begin
        if (start)              state_d = S_FETCH;
        else if (sleep_request) state_d = S_SLEEP;
      end
      S_FETCH: begin
        if (mem_ready)          state_d = S_DECODE;
        else if (cnt == TO_LAST) state_d = S_FAULT;
        else                    op = CNT_INC;
      end
      S_DECODE: begin
        state_d = S_EXECUTE;
        op      = CNT_LOAD;
      end
      S_EXECUTE: begin
        if (exec_stall)    op = CNT_HOLD;
        else if (cnt == '0) state_d = S_WB;
        else               op = CNT_DEC;
      end
      S_WB: begin
        if (irq_take)           state_d = S_IRQ;
        else if (sleep_request) state_d = S_SLEEP;
        else                    state_d = S_FETCH;
      end
      S_SLEEP: begin
        if (irq_take)            state_d = S_IRQ;
        else if (wakeup_request) state_d = S_FETCH;
      end
      S_IRQ:   state_d = S_FETCH;
      S_FAULT: state_d = S_FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      irq_q         <= 1'b0;
      busy_q        <= 1'b0;
      ovf_q         <= 1'b0;
      retired_count <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= is_busy(state_d);
      // in-service flag drops at the first boundary not re-entering IRQ
      if (state_d == S_IRQ)     irq_q <= 1'b1;
      else if (state_q == S_WB) irq_q <= 1'b0;
      if (state_q == S_WB) begin
        retired_count <= retired_count + ONE;
        if (&retired_count) ovf_q <= 1'b1;
      end
    end
  end

  assign mem_req = (state_q == S_FETCH);
  assign irq_ack = (state_q == S_IRQ);
  assign fault   = (state_q == S_FAULT);
  assign state   = state_q;

  always_comb begin
    status            = '0;
    status[IRQ_BIT]   = irq_q;
    status[BUSY_BIT]  = busy_q;
    status[OVF_BIT]   = ovf_q;
    status[FAULT_BIT] = fault;
  end

endmodule
